// File: rtl/ramio_ctrl_pkg.sv
// Shared types for the SRAM byte-sequencing controller: FSM states and LSU size codes.
package ramio_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    // Index of the final byte of an access; the reserved size code behaves as a word.
    function automatic logic [1:0] last_idx(input logic [1:0] hb);
        case (hb)
            HB_BYTE: last_idx = 2'd0;
            HB_HALF: last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/ramio_ctrl_if.sv
// LSU-side request/response bus of the SRAM controller; the core stalls while stall is high.
interface ramio_ctrl_if;
    logic        cs;
    logic        we;
    logic [1:0]  hb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        stall;

    modport master (output cs, we, hb, addr, wdata, input rdata, done, stall);
    modport slave  (input cs, we, hb, addr, wdata, output rdata, done, stall);
endinterface

// File: rtl/ramio_ctrl.sv
// Splits LSU accesses into 1/2/4 SETUP-PULSE-HOLD byte cycles on an async SRAM.
// Latency: byte 3+P, half 2(2+P)+1, word 4(2+P)+1 cycles; the core is stalled until DONE.
module ramio_ctrl
    import ramio_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 19,
    parameter int PULSE_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ramio_ctrl_if.slave       bus,
    output logic [ADDR_W-1:0] mem_adr_o,
    input  logic [7:0]        mem_dq_i,
    output logic [7:0]        mem_dq_o,
    output logic              mem_dq_oe_o,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o
);

    localparam int               CNT_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

    state_t             state_q;
    logic [1:0]         idx_q, last_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  base_q, adr_q;
    logic [31:0]        wdata_q, rdata_q;
    logic               we_q;
    logic [7:0]         dq_q;
    logic               dq_oe_q, ce_n_q, oe_n_q, we_n_q, done_q;

    logic [1:0]         idx_d;
    logic [ADDR_W-1:0]  adr_d;
    logic [7:0]         byte_d;

    // Only the SRAM-sized slice of the byte address reaches the pins.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:ADDR_W];

    assign idx_d  = idx_q + 2'd1;
    assign adr_d  = base_q + ADDR_W'(idx_d);
    assign byte_d = wdata_q[{idx_d, 3'b000} +: 8];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            cnt_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            adr_q   <= '0;
            dq_q    <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cs) begin
                        state_q <= ST_SETUP;
                        idx_q   <= 2'd0;
                        last_q  <= last_idx(bus.hb);
                        base_q  <= bus.addr[ADDR_W-1:0];
                        wdata_q <= bus.wdata;
                        we_q    <= bus.we;
                        adr_q   <= bus.addr[ADDR_W-1:0];
                        dq_q    <= bus.wdata[7:0];
                        dq_oe_q <= bus.we;
                        ce_n_q  <= 1'b0;
                        if (!bus.we) begin
                            rdata_q <= '0;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_PULSE;
                    cnt_q   <= '0;
                    oe_n_q  <= we_q;
                    we_n_q  <= !we_q;
                end
                ST_PULSE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_HOLD;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        if (!we_q) begin
                            rdata_q[{idx_q, 3'b000} +: 8] <= mem_dq_i;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (idx_q == last_q) begin
                        state_q <= ST_DONE;
                        ce_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_SETUP;
                        idx_q   <= idx_d;
                        adr_q   <= adr_d;
                        dq_q    <= byte_d;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Combinational so the core freezes in the very cycle a request appears.
    assign bus.stall = (bus.cs && (state_q == ST_IDLE)) ||
                       (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_HOLD);

    assign bus.rdata = rdata_q;
    assign bus.done  = done_q;
    assign mem_adr_o   = adr_q;
    assign mem_dq_o    = dq_q;
    assign mem_dq_oe_o = dq_oe_q;
    assign ram_ce_n_o  = ce_n_q;
    assign ram_oe_n_o  = oe_n_q;
    assign ram_we_n_o  = we_n_q;

endmodule

// File: tb/tb_ramio_ctrl.sv
// Directed bench for ramio_ctrl with a behavioural 512Kx8 SRAM, PULSE_CYCLES=2.
module tb_ramio_ctrl;
    import ramio_ctrl_pkg::*;

    localparam int ADDR_W = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ramio_ctrl_if bus ();

    logic [ADDR_W-1:0] mem_adr;
    logic [7:0]        mem_dq_i, mem_dq_o;
    logic              dq_oe, ram_ce_n, ram_oe_n, ram_we_n;

    ramio_ctrl #(.ADDR_W(ADDR_W), .PULSE_CYCLES(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .mem_adr_o   (mem_adr),
        .mem_dq_i    (mem_dq_i),
        .mem_dq_o    (mem_dq_o),
        .mem_dq_oe_o (dq_oe),
        .ram_ce_n_o  (ram_ce_n),
        .ram_oe_n_o  (ram_oe_n),
        .ram_we_n_o  (ram_we_n)
    );

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    assign mem_dq_i = (!ram_oe_n && !ram_ce_n) ? mem[mem_adr] : 8'h00;
    always @(posedge clk) begin
        if (!ram_we_n && !ram_ce_n && dq_oe) mem[mem_adr] <= mem_dq_o;
    end

    int n_cmp = 0;
    int n_bad = 0;

    int   we_run = 0, we_pulses = 0, we_bad_pulses = 0, contention = 0, ce_windows = 0;
    logic ce_prev = 1'b1;
    always @(negedge clk) begin
        if (!ram_we_n) we_run++;
        else if (we_run != 0) begin
            we_pulses++;
            if (we_run != 2) we_bad_pulses++;
            we_run = 0;
        end
        if (!ram_oe_n && dq_oe) contention++;
        if (ce_prev && !ram_ce_n) ce_windows++;
        ce_prev = ram_ce_n;
    end

    task automatic clear_mon();
        #2;
        we_run = 0; we_pulses = 0; we_bad_pulses = 0; contention = 0; ce_windows = 0;
    endtask

    // One access with cs dropped after acceptance; checks done timing and stall shape.
    task automatic do_access(input logic w, input logic [1:0] h, input logic [31:0] a,
                             input logic [31:0] d, input int exp_len, input string name,
                             output logic [31:0] rd);
        int done_cyc = -1;
        int stall_bad = 0;
        rd = '0;
        @(negedge clk);
        bus.cs = 1'b1; bus.we = w; bus.hb = h; bus.addr = a; bus.wdata = d;
        for (int c = 0; c <= exp_len + 3 && done_cyc < 0; c++) begin
            if (c == 1) bus.cs = 1'b0;
            #1;
            if (bus.stall !== ((c < exp_len) ? 1'b1 : 1'b0)) stall_bad++;
            if (bus.done === 1'b1) begin
                done_cyc = c;
                rd = bus.rdata;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done_cyc != exp_len) begin
            n_bad++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_len);
        end
        n_cmp++;
        if (stall_bad != 0) begin
            n_bad++;
            $display("FAIL %s stall_shape: got %0d bad cycles expected 0", name, stall_bad);
        end
    endtask

    task automatic test_reset();
        bus.cs = 1'b0; bus.we = 1'b0; bus.hb = HB_BYTE; bus.addr = '0; bus.wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if ({ram_ce_n, ram_oe_n, ram_we_n} !== 3'b111) begin n_bad++;
            $display("FAIL reset_strobes: got %b expected 111", {ram_ce_n, ram_oe_n, ram_we_n}); end
        n_cmp++; if (mem_adr !== '0) begin n_bad++;
            $display("FAIL reset_adr: got %h expected 0", mem_adr); end
        n_cmp++; if ({dq_oe, mem_dq_o} !== 9'h000) begin n_bad++;
            $display("FAIL reset_dq: got oe=%b dq=%h expected 0/00", dq_oe, mem_dq_o); end
        n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++;
            $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
        n_cmp++; if ({bus.done, bus.stall} !== 2'b00) begin n_bad++;
            $display("FAIL reset_done_stall: got %b expected 00", {bus.done, bus.stall}); end
    endtask

    task automatic test_word_write();
        logic [31:0] rd;
        clear_mon();
        do_access(1'b1, HB_WORD, 32'h100, 32'hDEADBEEF, 17, "word_wr", rd);
        n_cmp++; if ({mem[19'h103], mem[19'h102], mem[19'h101], mem[19'h100]} !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL word_wr_mem: got %h%h%h%h expected DEADBEEF",
                              mem[19'h103], mem[19'h102], mem[19'h101], mem[19'h100]); end
        n_cmp++; if (we_pulses != 4 || we_bad_pulses != 0) begin n_bad++;
            $display("FAIL word_wr_we_pulses: got %0d pulses %0d bad expected 4/0", we_pulses, we_bad_pulses); end
    endtask

    task automatic test_word_read();
        logic [31:0] rd;
        clear_mon();
        do_access(1'b0, HB_WORD, 32'h100, 32'h0, 17, "word_rd", rd);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++;
            $display("FAIL word_rd_data: got %h expected DEADBEEF", rd); end
        n_cmp++; if (contention != 0 || we_pulses != 0) begin n_bad++;
            $display("FAIL word_rd_bus: got contention=%0d we_pulses=%0d expected 0/0", contention, we_pulses); end
    endtask

    task automatic test_byte_read();
        logic [31:0] rd;
        clear_mon();
        do_access(1'b0, HB_BYTE, 32'h102, 32'h0, 5, "byte_rd", rd);
        n_cmp++; if (rd !== 32'h000000AD) begin n_bad++;
            $display("FAIL byte_rd_data: got %h expected 000000AD", rd); end
        n_cmp++; if (ce_windows != 1) begin n_bad++;
            $display("FAIL byte_rd_ce_windows: got %0d expected 1", ce_windows); end
    endtask

    task automatic test_half_wrap();
        logic [31:0] rd;
        do_access(1'b1, HB_HALF, 32'h0007FFFF, 32'h0000A55A, 9, "half_wr", rd);
        n_cmp++; if ({mem[19'h00000], mem[19'h7FFFF]} !== 16'hA55A) begin n_bad++;
            $display("FAIL half_wrap_mem: got %h%h expected A55A", mem[19'h00000], mem[19'h7FFFF]); end
        do_access(1'b0, HB_HALF, 32'h0007FFFF, 32'h0, 9, "half_rd", rd);
        n_cmp++; if (rd !== 32'h0000A55A) begin n_bad++;
            $display("FAIL half_wrap_rd: got %h expected 0000A55A", rd); end
    endtask

    task automatic test_hb11_misaligned();
        logic [31:0] rd;
        mem[19'h104] = 8'h00;
        do_access(1'b0, 2'b11, 32'h101, 32'h0, 17, "hb11_rd", rd);
        n_cmp++; if (rd !== 32'h00DEADBE) begin n_bad++;
            $display("FAIL hb11_misaligned: got %h expected 00DEADBE", rd); end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.hb = HB_WORD; bus.addr = 32'h200; bus.wdata = 32'h11223344;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) bus.cs = 1'b0;
        end
        n_cmp++; if (ram_we_n !== 1'b0 || mem_adr !== 19'h201) begin n_bad++;
            $display("FAIL rst_mid_in_pulse: got we_n=%b adr=%h expected 0/201", ram_we_n, mem_adr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if ({ram_ce_n, ram_oe_n, ram_we_n, dq_oe, bus.done, bus.stall} !== 6'b111000) begin
            n_bad++; $display("FAIL rst_mid_outputs: got %b expected 111000",
                              {ram_ce_n, ram_oe_n, ram_we_n, dq_oe, bus.done, bus.stall}); end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        n_cmp++; if (done_seen != 0) begin n_bad++;
            $display("FAIL rst_mid_no_done: got %0d done pulses expected 0", done_seen); end
        n_cmp++; if (mem[19'h200] !== 8'h44) begin n_bad++;
            $display("FAIL rst_mid_byte0: got %h expected 44", mem[19'h200]); end
    endtask

    task automatic test_back_to_back();
        int stall_bad = 0, done_bad = 0;
        logic [31:0] rd1 = '0, rd2 = '0;
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.hb = HB_BYTE; bus.addr = 32'h102;
        for (int c = 0; c <= 13; c++) begin
            if (c == 1) bus.addr = 32'h101;
            if (c == 11) bus.cs = 1'b0;
            #1;
            if (bus.stall !== ((c == 5 || c >= 11) ? 1'b0 : 1'b1)) stall_bad++;
            if (bus.done !== ((c == 5 || c == 11) ? 1'b1 : 1'b0)) done_bad++;
            if (c == 5) rd1 = bus.rdata;
            if (c == 11) rd2 = bus.rdata;
            @(negedge clk);
        end
        n_cmp++; if (stall_bad != 0 || done_bad != 0) begin n_bad++;
            $display("FAIL b2b_timing: got stall_bad=%0d done_bad=%0d expected 0/0", stall_bad, done_bad); end
        n_cmp++; if (rd1 !== 32'h000000AD) begin n_bad++;
            $display("FAIL b2b_first: got %h expected 000000AD", rd1); end
        n_cmp++; if (rd2 !== 32'h000000BE) begin n_bad++;
            $display("FAIL b2b_second: got %h expected 000000BE", rd2); end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_word_read();
        test_byte_read();
        test_half_wrap();
        test_hb11_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
